// File: rtl/prog_loader_ram_32b_pkg.sv
// Shared constants for the program loader and its RAM: frame magic, memory geometry,
// the reset opcode and the loader state encoding.
// Optional feature: define LOADER_CHECKSUM_EN to require a trailing checksum byte per frame.
package prog_loader_ram_32b_pkg;

  localparam int unsigned Depth     = 32;
  localparam int unsigned AddrWidth = 5;

  localparam logic [7:0] Magic = 8'hA5;

  // CPU opcode: memory resets to NOPs so a held-off CPU released early runs harmlessly
  localparam logic [7:0] OpNop = 8'h00;

  typedef enum logic [2:0] {
    StIdle,
    StLen,
    StData,
`ifdef LOADER_CHECKSUM_EN
    StErr,
    StCsum
`else
    StErr
`endif
  } ld_state_e;

  // A length byte is usable when it names between 1 and Depth payload bytes
  function automatic logic len_ok(input logic [7:0] n);
    return (n != 8'd0) && (n <= 8'(Depth));
  endfunction

endpackage

// File: rtl/prog_loader_ram_32b_if.sv
// Loader byte stream plus CPU read port of the program RAM.
// master: host/CPU side; slave: the loader RAM.
interface prog_loader_ram_32b_if import prog_loader_ram_32b_pkg::*; ();

  logic                 ld_valid;
  logic [7:0]           ld_data;
  logic                 ld_ready;
  logic [AddrWidth-1:0] address;
  logic [7:0]           data_out;
  logic                 cpu_hold;
  logic                 load_done;
  logic                 load_err;

  modport master (
    output ld_valid, ld_data, address,
    input  ld_ready, data_out, cpu_hold, load_done, load_err
  );

  modport slave (
    input  ld_valid, ld_data, address,
    output ld_ready, data_out, cpu_hold, load_done, load_err
  );

endinterface

// File: rtl/prog_ram_32x8.sv
// 32x8 program RAM: synchronous write, combinational read, synchronous clear to NOP.
// A read of the address being written returns the old byte until the next cycle.
module prog_ram_32x8 import prog_loader_ram_32b_pkg::*; (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 we,
  input  logic [AddrWidth-1:0] waddr,
  input  logic [7:0]           wdata,
  input  logic [AddrWidth-1:0] raddr,
  output logic [7:0]           rdata
);

  logic [7:0] mem_q [Depth];

  // Storage: reset clears every byte, otherwise one write per cycle
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned i = 0; i < Depth; i++) begin
        mem_q[AddrWidth'(i)] <= OpNop;
      end
    end else if (we) begin
      mem_q[waddr] <= wdata;
    end
  end

  assign rdata = mem_q[raddr];

endmodule

// File: rtl/prog_loader_ram_32b.sv
// Writable program memory with a framed byte-stream loader (magic, length, payload
// and, with LOADER_CHECKSUM_EN defined, a trailing mod-256 checksum of length+payload).
// The CPU is held off while a frame is in flight or after a failed frame.
module prog_loader_ram_32b import prog_loader_ram_32b_pkg::*; (
  input  logic                  clk,
  input  logic                  rst,
  prog_loader_ram_32b_if.slave  bus
);

  ld_state_e            state_q, state_d;
  logic [5:0]           len_q, len_d;
  logic [AddrWidth-1:0] ptr_q, ptr_d;
  logic                 hold_q, hold_d;
  logic                 done_q, done_d;
  logic                 err_q, err_d;
`ifdef LOADER_CHECKSUM_EN
  logic [7:0]           sum_q, sum_d;
`endif

  logic       ld_ready;
  logic       accept;
  logic       last_byte;
  logic       we;
  logic [7:0] rdata;

  // The loader never back-pressures the host
  assign ld_ready  = 1'b1;
  assign accept    = bus.ld_valid & ld_ready;
  assign last_byte = (ptr_q == AddrWidth'(len_q - 6'd1));

  // Next-state, pointer, sum and flag updates for one accepted byte
  always_comb begin
    state_d = state_q;
    len_d   = len_q;
    ptr_d   = ptr_q;
    hold_d  = hold_q;
    err_d   = err_q;
    done_d  = 1'b0;
    we      = 1'b0;
`ifdef LOADER_CHECKSUM_EN
    sum_d   = sum_q;
`endif
    if (accept) begin
      unique case (state_q)
        StIdle, StErr: begin
          // Non-magic bytes are dropped; a magic byte keeps load_err as it was
          if (bus.ld_data == Magic) begin
            state_d = StLen;
            hold_d  = 1'b1;
          end
        end
        StLen: begin
          if (len_ok(bus.ld_data)) begin
            len_d   = bus.ld_data[5:0];
            ptr_d   = '0;
`ifdef LOADER_CHECKSUM_EN
            sum_d   = bus.ld_data;
`endif
            state_d = StData;
          end else begin
            state_d = StErr;
            err_d   = 1'b1;
          end
        end
        StData: begin
          we    = 1'b1;
          ptr_d = ptr_q + 1'b1;
`ifdef LOADER_CHECKSUM_EN
          sum_d = sum_q + bus.ld_data;
          if (last_byte) begin
            state_d = StCsum;
          end
`else
          if (last_byte) begin
            state_d = StIdle;
            done_d  = 1'b1;
            hold_d  = 1'b0;
            err_d   = 1'b0;
          end
`endif
        end
`ifdef LOADER_CHECKSUM_EN
        StCsum: begin
          if (bus.ld_data == sum_q) begin
            state_d = StIdle;
            done_d  = 1'b1;
            hold_d  = 1'b0;
            err_d   = 1'b0;
          end else begin
            state_d = StErr;
            err_d   = 1'b1;
          end
        end
`endif
        default: state_d = StIdle;
      endcase
    end
  end

  // Loader state register; reset also aborts any frame in flight
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      len_q   <= '0;
      ptr_q   <= '0;
      hold_q  <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
`ifdef LOADER_CHECKSUM_EN
      sum_q   <= '0;
`endif
    end else begin
      state_q <= state_d;
      len_q   <= len_d;
      ptr_q   <= ptr_d;
      hold_q  <= hold_d;
      done_q  <= done_d;
      err_q   <= err_d;
`ifdef LOADER_CHECKSUM_EN
      sum_q   <= sum_d;
`endif
    end
  end

  prog_ram_32x8 u_ram (
    .clk   (clk),
    .rst   (rst),
    .we    (we),
    .waddr (ptr_q),
    .wdata (bus.ld_data),
    .raddr (bus.address),
    .rdata (rdata)
  );

  assign bus.ld_ready  = ld_ready;
  assign bus.data_out  = rdata;
  assign bus.cpu_hold  = hold_q;
  assign bus.load_done = done_q;
  assign bus.load_err  = err_q;

endmodule

// File: doc/prog_loader_ram_32b.md
# prog_loader_ram_32B

Writable 32-byte program memory with a byte-stream loader, replacing the fixed demo ROM as the CPU's instruction/data source. An external host pushes a framed program (magic, length, payload, optional checksum) over a valid/ready byte port. The CPU reads through the same 5-bit address / 8-bit data port the ROM presented. The CPU is held off while a load is in progress or after a failed load.

## Interface
Parameters:
- DEPTH, 32, number of bytes of program memory (address width 5).
- MAGIC, 8'hA5, frame start byte.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst  input  1  synchronous, active-high reset.
- ld_valid  input  1  host byte valid.
- ld_data  input  8  host byte.
- ld_ready  output  1  loader accepts `ld_data` when `ld_valid` and `ld_ready` are both high.
- address  input  5  CPU read address.
- data_out  output  8  CPU read data, combinational from `address`.
- cpu_hold  output  1  CPU must stall while high.
- load_done  output  1  one-cycle pulse on successful frame completion.
- load_err  output  1  sticky frame error flag.

## Operation
- Byte accepted = `ld_valid & ld_ready` on a rising edge. At most one byte is accepted per cycle.
- FSM states: IDLE, LEN, DATA, CSUM, ERR. `ld_ready` = 1 in every state.
- IDLE:
  - MAGIC accepted -> LEN, `cpu_hold` <= 1.
  - Any other byte is discarded; the state does not change.
- LEN:
  - Byte N in 1..32: latch N, clear the write pointer and running sum, add N to the sum -> DATA.
  - N = 0 or N > 32: -> ERR.
- DATA:
  - Each accepted byte writes `mem[ptr]`, increments `ptr`, and adds the byte to the sum.
  - After the Nth byte: -> CSUM when CHECKSUM is compiled in, otherwise -> IDLE (success).
- CSUM:
  - Byte equal to the sum: -> IDLE (success).
  - Any other value: -> ERR.
- Success: `load_done` pulses for 1 cycle; `cpu_hold` <= 0; `load_err` <= 0.
- ERR:
  - `load_err` = 1 and `cpu_hold` = 1.
  - Non-MAGIC bytes are discarded.
  - MAGIC -> LEN; `load_err` stays 1 until a later success.
- Sum arithmetic: 8-bit, modulo 256, covering the length byte plus all payload bytes.
- Bytes at addresses >= N keep their previous contents.
- A failed load leaves partially written memory. `cpu_hold` stays high until a good load completes.
- A MAGIC byte seen inside LEN/DATA/CSUM is treated as an ordinary byte, not a restart.
- `data_out = mem[address]`, combinational. When a read and a write hit the same address in the same cycle, the read returns the old value; the new value is visible the next cycle.

## Timing
- Reset values:
  - state IDLE, `cpu_hold` 0, `load_done` 0, `load_err` 0, `ld_ready` 1.
  - All 32 memory bytes 8'h00 (NOP).
  - `ptr`, N and sum are 0.
- Reset mid-load aborts the frame and applies all reset values, including clearing memory.
- `cpu_hold` rises the cycle after MAGIC is accepted.
- Written bytes are readable the cycle after acceptance.
- Frame of N payload bytes with no gaps: `load_done` is high in the cycle after the last frame byte (checksum, or the Nth payload byte) is accepted.
  - N+3 cycles from MAGIC when CHECKSUM is compiled in; N+2 without it.
  - `cpu_hold` falls in the same cycle `load_done` is high.
- `ld_valid` low cycles stall the FSM with no state change.
- No timeout exists.

## Configuration
- Macro: LOADER_CHECKSUM_EN.
- Defined: the CSUM state exists, a trailing checksum byte is required, and a mismatch -> ERR.
- Undefined: the CSUM state and sum register are removed. Success occurs directly after the Nth payload byte. The only remaining error sources are N = 0 and N > 32.

## Structure
- Shared package (alongside the CPU opcode constants): MAGIC value, FSM state encoding, DEPTH and address width.
- Sub-module `prog_ram_32x8`:
  - Synchronous write port (we, waddr, wdata).
  - Combinational read port.
  - Synchronous reset clears all bytes.
- The loader FSM, pointer and sum live in the top.

## Test plan
- Reset, no stimulus -> `data_out` = 8'h00 for all 32 addresses; `cpu_hold` = 0, `load_err` = 0, `ld_ready` = 1.
- Back-to-back frame A5, 03, 01, 05, 1B, csum 8'h24 -> `load_done` pulse; `mem[0..2]` = 01, 05, 1B; `mem[3]` unchanged; `cpu_hold` high for exactly the frame duration.
- Same frame with csum 8'h25 -> ERR, `load_err` = 1, `cpu_hold` stays 1. A following good frame clears both flags and pulses `load_done`.
- Length 00 and length 21 (33) -> immediate ERR; the write port never fires.
- Garbage 00, FF, 3C before A5, plus random `ld_valid` gaps mid-frame -> garbage is ignored; the result is identical to the gap-free load.
- Full 32-byte load followed by rst asserted during a second load's DATA phase -> all memory reads 00, state IDLE, all flags 0.
